// File: rtl/mem_burst_pkg.sv
// Shared definitions for the burst memory: FSM state encoding and byte-lane helper.
package mem_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_WBURST = 2'd2,
        ST_RBURST = 2'd3
    } state_t;

    function automatic int lanes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/mem_burst_ram.sv
// Single-port RAM with per-byte write enables and a registered read port.
module mem_burst_ram
    import mem_burst_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int ADDR  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               re,
    input  logic [WIDTH/8-1:0] we,
    input  logic [ADDR-1:0]    addr,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata
);

    localparam int LANES = lanes(WIDTH);

    // One narrow array per lane keeps byte writes independent and maps onto BRAM byte-write.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_q;

        always_ff @(posedge clk) begin
            if (we[gi]) begin
                lane_mem[addr] <= wdata[8*gi +: 8];
            end
        end

        // Read register only updates on read beats so rdata holds between bursts.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_q <= '0;
            end else if (re) begin
                lane_q <= lane_mem[addr];
            end
        end

        assign rdata[8*gi +: 8] = lane_q;
    end

endmodule

// File: rtl/mem_burst.sv
// Burst memory controller: command handshake, optional wait states, wrapping
// multi-beat read/write bursts with byte enables, and out-of-range rejection.
module mem_burst
    import mem_burst_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int ADDR  = 8,
    parameter int LAT   = 1,
    parameter int BLW   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    output logic               ready,
    input  logic               wrbar,
    input  logic [ADDR-1:0]    addr,
    input  logic [BLW-1:0]     blen,
    input  logic               wvalid,
    output logic               wready,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] be,
    output logic               rvalid,
    output logic [WIDTH-1:0]   rdata,
    output logic               done,
    output logic               err
);

    localparam int              LANES    = lanes(WIDTH);
    localparam logic [ADDR:0]   DEPTH_W  = (ADDR+1)'(DEPTH);
    localparam logic [ADDR-1:0] LAST_PTR = ADDR'(DEPTH - 1);
    localparam logic [3:0]      LAT_W    = 4'(LAT);
    localparam bit              DIRECT   = (LAT == 0);

    state_t          state_reg, state_next;
    logic            is_write_reg;
    logic [ADDR-1:0] ptr_reg;
    logic [BLW-1:0]  beat_reg;
    logic [3:0]      wait_reg;
    logic            rvalid_reg, done_reg, err_reg;

    logic            in_range, accept;
    logic            wr_beat, rd_beat, beat_fire, last_beat;
    logic [ADDR-1:0] ptr_next;
    logic [LANES-1:0] ram_we;

    assign in_range  = ({1'b0, addr} < DEPTH_W);
    assign accept    = (state_reg == ST_IDLE) && valid && in_range;
    assign wr_beat   = (state_reg == ST_WBURST) && wvalid;
    assign rd_beat   = (state_reg == ST_RBURST);
    assign beat_fire = wr_beat || rd_beat;
    assign last_beat = beat_fire && (beat_reg == '0);
    assign ptr_next  = (ptr_reg == LAST_PTR) ? '0 : ptr_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (valid && in_range) begin
                    if (DIRECT) begin
                        state_next = wrbar ? ST_WBURST : ST_RBURST;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_reg == 4'd1) begin
                    state_next = is_write_reg ? ST_WBURST : ST_RBURST;
                end
            end
            ST_WBURST: begin
                if (wvalid && (beat_reg == '0)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RBURST: begin
                if (beat_reg == '0) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        ready  = (state_reg == ST_IDLE);
        wready = (state_reg == ST_WBURST);
    end

    // Burst context, counters and the registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_write_reg <= 1'b0;
            ptr_reg      <= '0;
            beat_reg     <= '0;
            wait_reg     <= '0;
            rvalid_reg   <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            rvalid_reg <= rd_beat;
            done_reg   <= last_beat;
            err_reg    <= (state_reg == ST_IDLE) && valid && !in_range;
            if (accept) begin
                is_write_reg <= wrbar;
                ptr_reg      <= addr;
                beat_reg     <= blen;
                wait_reg     <= LAT_W;
            end
            if (state_reg == ST_WAIT) begin
                wait_reg <= wait_reg - 1'b1;
            end
            if (beat_fire) begin
                ptr_reg  <= ptr_next;
                beat_reg <= beat_reg - 1'b1;
            end
        end
    end

    assign ram_we = wr_beat ? be : '0;
    assign rvalid = rvalid_reg;
    assign done   = done_reg;
    assign err    = err_reg;

    mem_burst_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .re    (rd_beat),
        .we    (ram_we),
        .addr  (ptr_reg),
        .wdata (wdata),
        .rdata (rdata)
    );

endmodule

// File: doc/mem_burst.md
# mem_burst

Parametrised single-port burst memory: next generation of the `memory` block in `6_sequentialmemory`. It keeps the `valid`/`ready` command handshake and `wrbar` write/read select, and adds:
- multi-beat bursts with wrap-around addressing
- byte-enable writes
- configurable access latency
- out-of-range error reporting

It sits behind a bus master or testbench task that issues one command and then streams data beats.

## Interface
- `WIDTH`, 32, data word width; must be a multiple of 8
- `DEPTH`, 256, number of words; need not be a power of 2
- `ADDR`, 8, address width; must satisfy 2^ADDR >= DEPTH
- `LAT`, 1, wait cycles between command accept and first beat; range 0..15
- `BLW`, 4, burst-length field width; maximum burst is 2^BLW beats

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `valid`  in  1  command valid
- `ready`  out  1  command accepted when `valid && ready`
- `wrbar`  in  1  1 = write burst, 0 = read burst; sampled at accept
- `addr`  in  ADDR  start word address; sampled at accept
- `blen`  in  BLW  beats minus 1; sampled at accept
- `wvalid`  in  1  write beat valid
- `wready`  out  1  write beat accepted when `wvalid && wready`
- `wdata`  in  WIDTH  write beat data
- `be`  in  WIDTH/8  byte enables for the write beat; bit i covers `wdata[8i+7:8i]`
- `rvalid`  out  1  read beat valid; no backpressure
- `rdata`  out  WIDTH  read beat data
- `done`  out  1  one-cycle pulse when a burst completes
- `err`  out  1  one-cycle pulse when a command is rejected

## Operation
FSM states: IDLE, WAIT, WBURST, RBURST.
- IDLE: `ready`=1. On `valid`:
  - if `addr >= DEPTH`: go to IDLE, no memory access, pulse `err` next cycle.
  - else capture `wrbar`/`addr`/`blen`, load beat counter = `blen`, load wait counter = LAT. Go to WAIT, or directly to WBURST/RBURST if LAT=0.
- WAIT: decrement wait counter each cycle. At 1, go to WBURST or RBURST per the captured `wrbar`.
- WBURST: `wready`=1. Each edge with `wvalid`:
  - write the enabled bytes at the pointer; disabled bytes are unchanged;
  - advance the pointer; decrement the beat counter.
  - On the beat with counter 0, go to IDLE.
  - `wvalid`=0 stalls with no penalty.
- RBURST: each edge registers `mem[ptr]` into `rdata`, sets `rvalid`=1, advances the pointer and decrements the counter. On the beat with counter 0, go to IDLE.
- Pointer wrap: `ptr == DEPTH-1` advances to 0. The pointer is ADDR bits wide with no carry-out.
- `valid` outside IDLE is ignored (`ready`=0). A command must be held until accepted.

## Timing
- Reset values: state IDLE; `ready`=1; `wready`=0; `rvalid`=0; `rdata`=0; `done`=0; `err`=0. Memory contents are not reset.
- Reset mid-burst: FSM is forced to IDLE immediately. Partially written beats remain; remaining beats are dropped.
- Command accepted at edge E0. Burst state is entered at edge E0+LAT (E0 when LAT=0).
- Write: `wready` rises in the cycle after edge E0+LAT. Minimum burst duration is blen+1 cycles.
- Read: `rvalid` is high for exactly blen+1 consecutive cycles, starting in the cycle after edge E0+LAT+1.
- `done` is asserted in the first IDLE cycle after the last beat:
  - read: coincides with the last `rvalid` cycle;
  - write: the cycle after the last write edge.
- Back-to-back: a new command can be accepted in the `done` cycle.
- `err` is asserted in the cycle after the rejecting edge; `ready` stays 1.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Structure
- Package `mem_burst_pkg`: state encoding constants (IDLE=0, WAIT=1, WBURST=2, RBURST=3) and the `WIDTH`/8 byte-lane count function.
- Sub-module `mem_burst_ram`: synchronous single-port RAM with a per-byte write-enable vector and registered read. The FSM, counters and pointer live in `mem_burst`.

## Test plan
- Reset, then idle: `ready`=1, `wready`/`rvalid`/`done`/`err`=0.
- LAT=1:
  - write burst addr=0, blen=7, `be`=all ones, `wdata` = 0x10..0x17, no stalls;
  - then read burst addr=0, blen=7;
  - required: `rvalid` for 8 cycles returning 0x10..0x17, first beat 2 cycles after accept, `done` on the last beat.
- Wrap-around (DEPTH=256):
  - write blen=3 at addr=254 with 0xA0..0xA3, `wvalid` dropped for 2 cycles mid-burst;
  - read back addr=254, blen=3;
  - required: 0xA0, 0xA1, 0xA2, 0xA3 from locations 254, 255, 0, 1.
- Byte enable:
  - write 0xFFFFFFFF to addr 5;
  - then write 0x12345678 to addr 5 with `be`=4'b0101;
  - read addr 5 -> 0xFF34FF78.
- Out of range (DEPTH=200): `valid` with addr=210 -> `err` pulse 1 cycle, no `wready`, no `rvalid`; memory unchanged.
- Reset mid-operation:
  - `rst` asserted after 3 of 8 write beats;
  - required: outputs at reset values immediately;
  - reading back shows beats 0-2 written and beats 3-7 holding old data.
